issue_scheduler: RTL

- Issue unit behind the dispatcher's four reservation stations: integer, load/store, multiply and divide.
- Each cycle it grants at most one ready station a read/issue, which is the rd strobe into that station.
- It schedules CDB ownership ahead of time, so no two execution units broadcast on the CDB in the same cycle.
- It holds issue of a second divide while the non-pipelined divider is busy, and arbitrates round-robin among stations that can issue.

---
 rtl/issue_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/issue_scheduler.sv
// issue_scheduler: issue arbiter behind the integer, load/store, multiply and
// divide reservation stations. Each cycle it grants at most one station and
// reserves the CDB slot that grant's result will use. This keeps two execution
// units from ever broadcasting in the same cycle.
//
// Optional build macro: ISSUE_SCHED_PERF_EN adds o_cdb_stall_cnt. That output
// is a saturating count of cycles where some station was ready but no grant
// was made.
//
// Station handshake: i_*_rdy means "this station holds an issuable
// instruction". o_*_rd is the matching pop strobe. It is combinational, never
// high without its rdy, and at most one strobe is high per cycle. The station
// consumes the instruction on the rising edge where its strobe is high. A rdy
// that drops before it is granted leaves no trace in the scheduler.
//
// DIV_LAT must be >= every other latency and >= 2. The slot table is sized by
// DIV_LAT, so a smaller value would index past the top slot.
module issue_scheduler #(
  parameter int INT_LAT   = 1,
  parameter int LD_ST_LAT = 2,
  parameter int MULT_LAT  = 4,
  parameter int DIV_LAT   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_int_rdy,
  input  logic       i_ld_st_rdy,
  input  logic       i_mult_rdy,
  input  logic       i_div_rdy,
  output logic       o_int_rd,
  output logic       o_ld_st_rd,
  output logic       o_mult_rd,
  output logic       o_div_rd,
  output logic       o_cdb_busy,
  output logic [1:0] o_cdb_owner,
  output logic       o_div_busy
`ifdef ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0] o_cdb_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DIV_LAT);

  localparam logic [1:0] ID_INT   = 2'd0;
  localparam logic [1:0] ID_LD_ST = 2'd1;
  localparam logic [1:0] ID_MULT  = 2'd2;
  localparam logic [1:0] ID_DIV   = 2'd3;

  // Slot k of the table describes the CDB k cycles from now; slot 0 is now.
  logic [DIV_LAT:0] sched_q;
  logic [DIV_LAT:0] sched_d;
  logic [1:0]       owner_q [DIV_LAT+1];
  logic [1:0]       owner_d [DIV_LAT+1];

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;
  logic [1:0]       rr_ptr_q;
  logic [1:0]       rr_ptr_d;

  logic [3:0]       rdy_vec;
  logic [3:0]       elig;
  logic [3:0]       grant;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;

  assign rdy_vec = {i_div_rdy, i_mult_rdy, i_ld_st_rdy, i_int_rdy};

  // Eligibility depends only on rdy inputs and registered state, so there is
  // no path from the strobes back into this logic.
  always_comb begin
    elig    = '0;
    elig[0] = i_int_rdy   & ~sched_q[INT_LAT];
    elig[1] = i_ld_st_rdy & ~sched_q[LD_ST_LAT];
    elig[2] = i_mult_rdy  & ~sched_q[MULT_LAT];
    elig[3] = i_div_rdy   & ~sched_q[DIV_LAT] & (div_cnt_q == '0);
  end

  // Round-robin pick: the first eligible station scanning from rr_ptr; reset
  // suppresses every grant.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_ptr_q + 2'(i);
      if (!grant_any && elig[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (i_rst) begin
      grant_any = 1'b0;
    end
    grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  end

  assign o_int_rd   = grant[0];
  assign o_ld_st_rd = grant[1];
  assign o_mult_rd  = grant[2];
  assign o_div_rd   = grant[3];

  // The table shifts one slot per cycle. A grant to r lands in slot L(r)-1 of
  // the next state, which is L(r) cycles after the issue cycle.
  always_comb begin
    sched_d = {1'b0, sched_q[DIV_LAT:1]};
    for (int k = 0; k < DIV_LAT; k++) begin
      owner_d[k] = owner_q[k+1];
    end
    owner_d[DIV_LAT] = 2'd0;
    if (grant_any) begin
      case (grant_idx)
        ID_INT: begin
          sched_d[INT_LAT-1] = 1'b1;
          owner_d[INT_LAT-1] = ID_INT;
        end
        ID_LD_ST: begin
          sched_d[LD_ST_LAT-1] = 1'b1;
          owner_d[LD_ST_LAT-1] = ID_LD_ST;
        end
        ID_MULT: begin
          sched_d[MULT_LAT-1] = 1'b1;
          owner_d[MULT_LAT-1] = ID_MULT;
        end
        default: begin
          sched_d[DIV_LAT-1] = 1'b1;
          owner_d[DIV_LAT-1] = ID_DIV;
        end
      endcase
    end
  end

  // Divider occupancy and the round-robin pointer.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (grant[3]) begin
      div_cnt_d = CNT_W'(DIV_LAT - 1);
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - 1'b1;
    end
    rr_ptr_d = grant_any ? (grant_idx + 2'd1) : rr_ptr_q;
  end

  // State registers; reset throws away every pending CDB reservation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sched_q   <= '0;
      div_cnt_q <= '0;
      rr_ptr_q  <= '0;
      for (int k = 0; k <= DIV_LAT; k++) begin
        owner_q[k] <= 2'd0;
      end
    end else begin
      sched_q   <= sched_d;
      div_cnt_q <= div_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      for (int k = 0; k <= DIV_LAT; k++) begin
        owner_q[k] <= owner_d[k];
      end
    end
  end

  assign o_cdb_busy  = sched_q[0];
  assign o_cdb_owner = sched_q[0] ? owner_q[0] : 2'd0;
  assign o_div_busy  = (div_cnt_q != '0);

`ifdef ISSUE_SCHED_PERF_EN
  logic [31:0] stall_cnt_q;

  // Count cycles with demand but no grant, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else if ((rdy_vec != 4'b0000) && !grant_any && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_cdb_stall_cnt = stall_cnt_q;
`else
  logic unused_rdy_vec;
  assign unused_rdy_vec = ^rdy_vec;
`endif

endmodule
